// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches 32-bit words over a
// req/ack handshake, latches them into the IR, decodes fields, and applies
// jump / jr redirects when the decoder consumes the instruction.
//
// Handshake: imem_req is held high in S_REQ with imem_addr == pc; a cycle
// with imem_req && imem_ack transfers imem_rdata into the IR. instr_valid
// is high while the IR holds an unconsumed word; a cycle with
// instr_valid && dec_ready consumes it. Any ack seen while imem_req is low
// carries no data and is discarded.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 8,
  parameter int          WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        dec_ready,
  input  logic        Muxif,
  input  logic        jr_sel,
  input  logic [31:0] jr_target,
  output logic        instr_valid,
  output logic [5:0]  Opcode,
  output logic [5:0]  Function,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] Imm,
  output logic [31:0] pc_plus4,
  output logic        fetch_err,
  output logic        align_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_RETRY = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state;
  logic [31:0]       pc;
  logic [31:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;

  // Fetch FSM: request, hold for the decoder, or back off one cycle on timeout.
  // imem_req resets low and is raised on the first clock after reset, so a
  // reset in the middle of a request drops it at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      ir          <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      wait_cnt    <= '0;
      pc_plus4    <= '0;
      fetch_err   <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      align_err <= 1'b0;
      case (state)
        S_REQ: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            // Ack wins even on the timeout-threshold cycle.
            ir          <= imem_rdata;
            instr_valid <= 1'b1;
            pc_plus4    <= pc + 32'd4;
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            state       <= S_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            fetch_err <= 1'b1;
            wait_cnt  <= '0;
            imem_req  <= 1'b0;
            state     <= S_RETRY;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (dec_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_REQ;
            if (!Muxif) begin
              pc <= pc_plus4;
            end else if (!jr_sel) begin
              pc <= {pc_plus4[31:28], ir[25:0], 2'b00};
            end else begin
              pc        <= {jr_target[31:2], 2'b00};
              align_err <= |jr_target[1:0];
            end
          end
        end
        S_RETRY: begin
          imem_req <= 1'b1;
          state    <= S_REQ;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= S_REQ;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign dbg_state = state;
  assign Opcode    = ir[31:26];
  assign Function  = ir[5:0];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign Imm       = ir[15:0];

endmodule
